cvi_trigger_event_regs: RTL and testbench
=========================================

Name: cvi_trigger_event_regs

Overview:
- Control-domain status/interrupt register block sitting directly downstream of the cross-domain trigger synchronisers.
- Consumes their single-cycle trigger pulses (e.g. resolution change, FIFO overflow, sync lost), already in the control clock domain.
- Latches each pulse into a sticky pending bit, counts events, and raises a maskable level interrupt.
- Exposes control, status and counters to the host over a 2-bit-address Avalon-MM slave with fixed read latency 1.

Parameters:
- NUM_EVENTS, 3, number of trigger inputs; legal range 1..30.
- COUNT_WIDTH, 16, width of both saturating event counters; legal range 1..32.

Ports:
- clk  input  1  control-domain clock; same clock as the trigger synchronisers' output side.
- rst  input  1  asynchronous active-high reset.
- trig_in  input  NUM_EVENTS  single-cycle trigger pulses, one per event source; any pattern, including all bits together.
- av_address  input  2  register word address.
- av_read  input  1  read strobe.
- av_write  input  1  write strobe.
- av_writedata  input  32  write data.
- av_readdata  output  32  read data, valid the cycle after av_read.
- av_readdatavalid  output  1  high exactly one cycle after each accepted av_read.
- go  output  1  control bit 0, driven to the capture stage.
- irq  output  1  level interrupt, registered.

Behaviour:
- Reset: every register and output is 0, with no exception: go, irq, av_readdata, av_readdatavalid, pending, enables, both counters. Reset is asynchronous assert, synchronous release.
- Register map (unused bits read 0; writes to them are ignored):
  - 0 CONTROL RW: bit0 = go; bits[NUM_EVENTS:1] = irq_enable[NUM_EVENTS-1:0].
  - 1 STATUS: bits[NUM_EVENTS-1:0] = pending. Write-1-to-clear per bit; writing 0 leaves the bit unchanged.
  - 2 COUNT0: event-0 counter, zero-extended to 32 bits. Any write clears it to 0; write data is ignored.
  - 3 COUNT_ALL: total events across all sources, zero-extended. Any write clears it.
- Pending update, each cycle: pending_next = (pending & ~clear_mask) | trig_in.
  - A set takes priority over a same-cycle W1C on that bit, so no event is lost.
- COUNT0, each cycle:
  - write-clear with trig_in[0] in the same cycle → 1;
  - write-clear alone → 0;
  - trig_in[0] alone → +1, saturating at 2^COUNT_WIDTH-1.
- COUNT_ALL, each cycle: add popcount(trig_in); multiple simultaneous triggers add more than 1.
  - Compute the sum at COUNT_WIDTH+ceil(log2(NUM_EVENTS+1)) bits and clamp to all-ones if it exceeds the maximum.
  - Same-cycle write-clear: result = popcount(trig_in), clamped.
  - Once saturated, the counter holds until cleared.
- Reads:
  - av_readdata is registered from the pre-update register values of the av_read cycle. A same-cycle write or trigger does not affect the returned value.
  - av_readdatavalid pulses 1 cycle later.
  - av_readdata holds its last value when no read is issued.
  - A simultaneous av_read and av_write to the same address is legal: the read returns the old value and the write takes effect.
- Interrupt: irq is registered, irq = |(pending & irq_enable).
  - Latency: trig_in at cycle N → pending at N+1 → irq at N+2.
  - W1C or disabling the enable at cycle N → irq deasserts at N+2.
- go: follows CONTROL bit0 with no extra delay (register output).
- No handshake back-pressure: the slave never stalls (no waitrequest). One read may be accepted per cycle.

Test Plan:
- Reset/defaults: assert rst mid-operation with pending=3'b101 and COUNT0=7 → all outputs 0 immediately; after release, reading addresses 0..3 returns 0.
- Sticky and irq timing: write CONTROL=0x5 (go=1, enable event1); pulse trig_in=3'b010 at cycle N → STATUS reads 0x2 and irq rises at N+2. Then write STATUS=0x2 → irq falls 2 cycles later and STATUS reads 0.
- Set beats clear: pending[0]=1; in one cycle write STATUS=0x1 while trig_in[0]=1 → STATUS still reads 0x1.
- Counting: pulse trig_in=3'b111 three times → COUNT0=3, COUNT_ALL=9. Clear COUNT_ALL in the same cycle as trig_in=3'b011 → COUNT_ALL=2.
- Saturation: COUNT_WIDTH=4; issue 20 trig_in[0] pulses → COUNT0=15 and COUNT_ALL=15. A further pulse leaves both unchanged.
- Read/write collision: with CONTROL=0x1, read and write CONTROL=0x0 in the same cycle → av_readdata=0x1 with valid at the next cycle; go=0 one cycle after the write.

Source files
------------

// File: rtl/cvi_trigger_event_regs.sv
// Control-domain status/interrupt registers fed by synchronised trigger pulses.
// Sticky pending bits, two saturating event counters, a maskable level irq, Avalon-MM slave (read latency 1).
module cvi_trigger_event_regs #(
   parameter int NUM_EVENTS  = 3,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EVENTS-1:0] trig_in,
   input  logic [1:0]            av_address,
   input  logic                  av_read,
   input  logic                  av_write,
   input  logic [31:0]           av_writedata,
   output logic [31:0]           av_readdata,
   output logic                  av_readdatavalid,
   output logic                  go,
   output logic                  irq
);

   localparam int PC_WIDTH  = $clog2(NUM_EVENTS + 1);
   localparam int SUM_WIDTH = COUNT_WIDTH + PC_WIDTH;

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
   localparam logic [SUM_WIDTH-1:0]   SUM_MAX = SUM_WIDTH'(CNT_MAX);

   localparam logic [1:0] ADDR_CONTROL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS    = 2'd1;
   localparam logic [1:0] ADDR_COUNT0    = 2'd2;
   localparam logic [1:0] ADDR_COUNT_ALL = 2'd3;

   logic                   go_q, go_d;
   logic [NUM_EVENTS-1:0]  irq_en_q, irq_en_d;
   logic [NUM_EVENTS-1:0]  pending_q, pending_d;
   logic [COUNT_WIDTH-1:0] count0_q, count0_d;
   logic [COUNT_WIDTH-1:0] count_all_q, count_all_d;
   logic [31:0]            readdata_q, readdata_d;
   logic                   readdatavalid_q, readdatavalid_d;
   logic                   irq_q, irq_d;

   logic                   wr_control, wr_status, wr_count0, wr_count_all;
   logic [NUM_EVENTS-1:0]  clear_mask;
   logic [PC_WIDTH-1:0]    trig_count;
   logic [SUM_WIDTH-1:0]   all_base, all_sum;
   logic [31:0]            rd_word;

   always_comb begin
      wr_control   = av_write && (av_address == ADDR_CONTROL);
      wr_status    = av_write && (av_address == ADDR_STATUS);
      wr_count0    = av_write && (av_address == ADDR_COUNT0);
      wr_count_all = av_write && (av_address == ADDR_COUNT_ALL);
      clear_mask   = wr_status ? av_writedata[NUM_EVENTS-1:0] : '0;
   end

   always_comb begin
      go_d     = go_q;
      irq_en_d = irq_en_q;
      if (wr_control) begin
         go_d     = av_writedata[0];
         irq_en_d = av_writedata[NUM_EVENTS:1];
      end
   end

   // A trigger landing in the same cycle as its W1C wins, so no event is dropped.
   always_comb begin
      pending_d = (pending_q & ~clear_mask) | trig_in;
   end

   always_comb begin
      count0_d = count0_q;
      if (wr_count0) begin
         count0_d = COUNT_WIDTH'(trig_in[0]);
      end else if (trig_in[0] && (count0_q != CNT_MAX)) begin
         count0_d = count0_q + COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      trig_count = '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         trig_count = trig_count + PC_WIDTH'(trig_in[i]);
      end
   end

   // Sum is kept wide enough that a multi-trigger add can never wrap before the clamp.
   always_comb begin
      all_base    = wr_count_all ? '0 : SUM_WIDTH'(count_all_q);
      all_sum     = all_base + SUM_WIDTH'(trig_count);
      count_all_d = (all_sum > SUM_MAX) ? CNT_MAX : all_sum[COUNT_WIDTH-1:0];
   end

   always_comb begin
      rd_word = '0;
      case (av_address)
         ADDR_CONTROL:   rd_word[NUM_EVENTS:0]    = {irq_en_q, go_q};
         ADDR_STATUS:    rd_word[NUM_EVENTS-1:0]  = pending_q;
         ADDR_COUNT0:    rd_word[COUNT_WIDTH-1:0] = count0_q;
         ADDR_COUNT_ALL: rd_word[COUNT_WIDTH-1:0] = count_all_q;
         default:        rd_word                  = '0;
      endcase
   end

   always_comb begin
      readdata_d      = av_read ? rd_word : readdata_q;
      readdatavalid_d = av_read;
      irq_d           = |(pending_q & irq_en_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         go_q            <= 1'b0;
         irq_en_q        <= '0;
         pending_q       <= '0;
         count0_q        <= '0;
         count_all_q     <= '0;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         irq_q           <= 1'b0;
      end else begin
         go_q            <= go_d;
         irq_en_q        <= irq_en_d;
         pending_q       <= pending_d;
         count0_q        <= count0_d;
         count_all_q     <= count_all_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         irq_q           <= irq_d;
      end
   end

   assign go               = go_q;
   assign irq              = irq_q;
   assign av_readdata      = readdata_q;
   assign av_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_cvi_trigger_event_regs.sv
// Bench for cvi_trigger_event_regs: directed scenarios plus randomized traffic
// checked against an integer-level model of the register block.
module tb_cvi_trigger_event_regs;

   localparam int NE   = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic [NE-1:0] trig_in;
   logic [1:0]    av_address;
   logic          av_read;
   logic          av_write;
   logic [31:0]   av_writedata;
   logic [31:0]   av_readdata;
   logic          av_readdatavalid;
   logic          go;
   logic          irq;

   int n_checks;
   int n_pass;

   int m_go, m_en, m_pend, m_c0, m_call, m_irq, m_rdata, m_rvalid;

   cvi_trigger_event_regs #(.NUM_EVENTS(NE), .COUNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .trig_in          (trig_in),
      .av_address       (av_address),
      .av_read          (av_read),
      .av_write         (av_write),
      .av_writedata     (av_writedata),
      .av_readdata      (av_readdata),
      .av_readdatavalid (av_readdatavalid),
      .go               (go),
      .irq              (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_go = 0; m_en = 0; m_pend = 0; m_c0 = 0; m_call = 0;
      m_irq = 0; m_rdata = 0; m_rvalid = 0;
   endfunction

   // One clock of the register block, computed from the pre-edge state.
   function automatic void model_step(input logic [2:0] t, input logic rd, input logic wr,
                                      input logic [1:0] a, input logic [31:0] wd);
      int rw, pc, clr, base;
      case (a)
         2'd0:    rw = m_en * 2 + m_go;
         2'd1:    rw = m_pend;
         2'd2:    rw = m_c0;
         default: rw = m_call;
      endcase
      pc    = int'(t[0]) + int'(t[1]) + int'(t[2]);
      m_irq = ((m_pend & m_en) != 0) ? 1 : 0;
      clr   = (wr && a == 2'd1) ? int'(wd[2:0]) : 0;
      m_pend = (m_pend & ~clr) | int'(t);
      if (wr && a == 2'd2) m_c0 = int'(t[0]);
      else if (t[0]) m_c0 = (m_c0 + 1 > CMAX) ? CMAX : m_c0 + 1;
      base   = (wr && a == 2'd3) ? 0 : m_call;
      m_call = (base + pc > CMAX) ? CMAX : base + pc;
      if (wr && a == 2'd0) begin
         m_go = int'(wd[0]);
         m_en = int'(wd[3:1]);
      end
      if (rd) m_rdata = rw;
      m_rvalid = rd ? 1 : 0;
   endfunction

   task automatic tick(input logic [2:0] t, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
      trig_in = t; av_read = rd; av_write = wr; av_address = a; av_writedata = wd;
      @(posedge clk);
      model_step(t, rd, wr, a, wd);
      #1;
      trig_in = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
   endtask

   task automatic test_reset();
      n_checks++; if (go !== 1'b0) $display("[TB] FAIL rst_go: got %0h expected 0", go); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("[TB] FAIL rst_irq: got %0h expected 0", irq); else n_pass++;
      n_checks++; if (av_readdata !== 32'h0) $display("[TB] FAIL rst_rdata: got %0h expected 0", av_readdata); else n_pass++;
      n_checks++; if (av_readdatavalid !== 1'b0) $display("[TB] FAIL rst_rvalid: got %0h expected 0", av_readdatavalid); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         tick(3'b000, 1'b1, 1'b0, 2'(a), 32'h0);
         n_checks++; if (av_readdatavalid !== 1'b1 || av_readdata !== 32'h0)
            $display("[TB] FAIL rst_read%0d: got v=%0h d=%0h expected v=1 d=0", a, av_readdatavalid, av_readdata);
         else n_pass++;
      end
   endtask

   task automatic test_sticky_irq();
      tick(3'b000, 1'b0, 1'b1, 2'd0, 32'h5);
      n_checks++; if (go !== 1'b1) $display("[TB] FAIL sticky_go: got %0h expected 1", go); else n_pass++;
      tick(3'b010, 1'b0, 1'b0, 2'd0, 32'h0);
      n_checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_n1: got %0h expected 0", irq); else n_pass++;
      tick(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
      n_checks++; if (irq !== 1'b1) $display("[TB] FAIL irq_n2: got %0h expected 1", irq); else n_pass++;
      tick(3'b000, 1'b1, 1'b0, 2'd1, 32'h0);
      n_checks++; if (av_readdata !== 32'h2) $display("[TB] FAIL sticky_status: got %0h expected 2", av_readdata); else n_pass++;
      tick(3'b000, 1'b0, 1'b1, 2'd1, 32'h2);
      n_checks++; if (irq !== 1'b1) $display("[TB] FAIL irq_clr_n1: got %0h expected 1", irq); else n_pass++;
      tick(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
      n_checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_clr_n2: got %0h expected 0", irq); else n_pass++;
      tick(3'b000, 1'b1, 1'b0, 2'd1, 32'h0);
      n_checks++; if (av_readdata !== 32'h0) $display("[TB] FAIL status_cleared: got %0h expected 0", av_readdata); else n_pass++;
   endtask

   task automatic test_set_beats_clear();
      tick(3'b001, 1'b0, 1'b0, 2'd0, 32'h0);
      tick(3'b001, 1'b0, 1'b1, 2'd1, 32'h1);
      tick(3'b000, 1'b1, 1'b0, 2'd1, 32'h0);
      n_checks++; if (av_readdata !== 32'h1) $display("[TB] FAIL set_beats_clear: got %0h expected 1", av_readdata); else n_pass++;
      tick(3'b000, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFF8);
      tick(3'b000, 1'b1, 1'b0, 2'd1, 32'h0);
      n_checks++; if (av_readdata !== 32'h1) $display("[TB] FAIL w0_keeps: got %0h expected 1", av_readdata); else n_pass++;
      tick(3'b000, 1'b0, 1'b1, 2'd1, 32'h1);
      tick(3'b000, 1'b1, 1'b0, 2'd1, 32'h0);
      n_checks++; if (av_readdata !== 32'h0) $display("[TB] FAIL w1c_alone: got %0h expected 0", av_readdata); else n_pass++;
   endtask

   task automatic test_counting();
      tick(3'b000, 1'b0, 1'b1, 2'd2, 32'h0);
      tick(3'b000, 1'b0, 1'b1, 2'd3, 32'h0);
      for (int i = 0; i < 3; i++) tick(3'b111, 1'b0, 1'b0, 2'd0, 32'h0);
      tick(3'b000, 1'b1, 1'b0, 2'd2, 32'h0);
      n_checks++; if (av_readdata !== 32'd3) $display("[TB] FAIL count0_3: got %0d expected 3", av_readdata); else n_pass++;
      tick(3'b000, 1'b1, 1'b0, 2'd3, 32'h0);
      n_checks++; if (av_readdata !== 32'd9) $display("[TB] FAIL countall_9: got %0d expected 9", av_readdata); else n_pass++;
      tick(3'b011, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF);
      tick(3'b000, 1'b1, 1'b0, 2'd3, 32'h0);
      n_checks++; if (av_readdata !== 32'd2) $display("[TB] FAIL countall_clr_trig: got %0d expected 2", av_readdata); else n_pass++;
      tick(3'b000, 1'b1, 1'b0, 2'd2, 32'h0);
      n_checks++; if (av_readdata !== 32'd4) $display("[TB] FAIL count0_4: got %0d expected 4", av_readdata); else n_pass++;
      tick(3'b001, 1'b0, 1'b1, 2'd2, 32'h0);
      tick(3'b000, 1'b1, 1'b0, 2'd2, 32'h0);
      n_checks++; if (av_readdata !== 32'd1) $display("[TB] FAIL count0_clr_trig: got %0d expected 1", av_readdata); else n_pass++;
   endtask

   task automatic test_saturation();
      tick(3'b000, 1'b0, 1'b1, 2'd2, 32'h0);
      tick(3'b000, 1'b0, 1'b1, 2'd3, 32'h0);
      for (int i = 0; i < 20; i++) tick(3'b001, 1'b0, 1'b0, 2'd0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         tick(3'b000, 1'b1, 1'b0, 2'd2, 32'h0);
         n_checks++; if (av_readdata !== 32'd15) $display("[TB] FAIL sat_count0_%0d: got %0d expected 15", k, av_readdata); else n_pass++;
         tick(3'b000, 1'b1, 1'b0, 2'd3, 32'h0);
         n_checks++; if (av_readdata !== 32'd15) $display("[TB] FAIL sat_countall_%0d: got %0d expected 15", k, av_readdata); else n_pass++;
         tick(3'b001, 1'b0, 1'b0, 2'd0, 32'h0);
      end
      // 12 + 2 = 14, then +3 must clamp rather than wrap.
      tick(3'b000, 1'b0, 1'b1, 2'd3, 32'h0);
      for (int i = 0; i < 4; i++) tick(3'b111, 1'b0, 1'b0, 2'd0, 32'h0);
      tick(3'b011, 1'b1, 1'b0, 2'd3, 32'h0);
      n_checks++; if (av_readdata !== 32'd12) $display("[TB] FAIL sat_pre12: got %0d expected 12", av_readdata); else n_pass++;
      tick(3'b111, 1'b1, 1'b0, 2'd3, 32'h0);
      n_checks++; if (av_readdata !== 32'd14) $display("[TB] FAIL sat_pre14: got %0d expected 14", av_readdata); else n_pass++;
      tick(3'b000, 1'b1, 1'b0, 2'd3, 32'h0);
      n_checks++; if (av_readdata !== 32'd15) $display("[TB] FAIL sat_multi_clamp: got %0d expected 15", av_readdata); else n_pass++;
   endtask

   task automatic test_collision();
      tick(3'b000, 1'b0, 1'b1, 2'd0, 32'h1);
      n_checks++; if (go !== 1'b1) $display("[TB] FAIL coll_go_set: got %0h expected 1", go); else n_pass++;
      tick(3'b000, 1'b1, 1'b1, 2'd0, 32'h0);
      n_checks++; if (av_readdatavalid !== 1'b1 || av_readdata !== 32'h1)
         $display("[TB] FAIL coll_read: got v=%0h d=%0h expected v=1 d=1", av_readdatavalid, av_readdata);
      else n_pass++;
      n_checks++; if (go !== 1'b0) $display("[TB] FAIL coll_go_clr: got %0h expected 0", go); else n_pass++;
      tick(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
      n_checks++; if (av_readdatavalid !== 1'b0 || av_readdata !== 32'h1)
         $display("[TB] FAIL coll_hold: got v=%0h d=%0h expected v=0 d=1", av_readdatavalid, av_readdata);
      else n_pass++;
   endtask

   task automatic test_midop_reset();
      tick(3'b000, 1'b0, 1'b1, 2'd0, 32'hF);
      tick(3'b000, 1'b0, 1'b1, 2'd1, 32'h7);
      tick(3'b000, 1'b0, 1'b1, 2'd2, 32'h0);
      for (int i = 0; i < 7; i++) tick(3'b101, 1'b0, 1'b0, 2'd0, 32'h0);
      tick(3'b000, 1'b1, 1'b0, 2'd1, 32'h0);
      n_checks++; if (av_readdata !== 32'h5) $display("[TB] FAIL midop_status: got %0h expected 5", av_readdata); else n_pass++;
      tick(3'b000, 1'b1, 1'b0, 2'd2, 32'h0);
      n_checks++; if (av_readdata !== 32'd7 || irq !== 1'b1)
         $display("[TB] FAIL midop_pre: got d=%0d irq=%0h expected d=7 irq=1", av_readdata, irq);
      else n_pass++;
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_checks++; if ({go, irq, av_readdatavalid} !== 3'b000 || av_readdata !== 32'h0)
         $display("[TB] FAIL midop_async: got go=%0h irq=%0h v=%0h d=%0h expected all 0", go, irq, av_readdatavalid, av_readdata);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         tick(3'b000, 1'b1, 1'b0, 2'(a), 32'h0);
         n_checks++; if (av_readdata !== 32'h0) $display("[TB] FAIL midop_read%0d: got %0h expected 0", a, av_readdata); else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [2:0]  t;
      logic        rd, wr;
      logic [1:0]  a;
      logic [31:0] wd;
      for (int i = 0; i < 400; i++) begin
         t  = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 3) == 0);
         a  = 2'($urandom_range(0, 3));
         wd = $urandom;
         tick(t, rd, wr, a, wd);
         n_checks++; if (go !== 1'(m_go)) $display("[TB] FAIL rnd_go@%0d: got %0h expected %0h", i, go, m_go); else n_pass++;
         n_checks++; if (irq !== 1'(m_irq)) $display("[TB] FAIL rnd_irq@%0d: got %0h expected %0h", i, irq, m_irq); else n_pass++;
         n_checks++; if (av_readdatavalid !== 1'(m_rvalid))
            $display("[TB] FAIL rnd_rvalid@%0d: got %0h expected %0h", i, av_readdatavalid, m_rvalid);
         else n_pass++;
         n_checks++; if (av_readdata !== 32'(m_rdata))
            $display("[TB] FAIL rnd_rdata@%0d: got %0h expected %0h", i, av_readdata, m_rdata);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      model_reset();
      rst = 1'b1;
      trig_in = '0; av_read = 1'b0; av_write = 1'b0; av_address = '0; av_writedata = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_sticky_irq();
      test_set_beats_clear();
      test_counting();
      test_saturation();
      test_collision();
      test_midop_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
